mem_arbiter: RTL and testbench

- Two-requester arbiter for the shared 256x16 single-port RAM.
- CPU port (read/write) serves the RISC processor; DBG port (read-only) serves the memory-dump/display path.
- Replaces the static dump/address mux. Every access runs as a req/ack handshake, and round-robin fairness is applied on contention.
- Sits between both requesters and the RAM. The RAM has a combinational read and writes on the clk edge while its write-enable is high.

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter_if.sv | 42 ++++
 rtl/mem_arbiter_rr_arb2.sv | 35 +++
 rtl/mem_arbiter.sv | 107 ++++++++++
 tb/tb_mem_arbiter.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared widths, FSM/owner encodings and the latched RAM access payload
// for the CPU/DBG memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } ram_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester handshakes, RAM port and status of the memory arbiter.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;

  logic          dbg_req;
  logic [AW-1:0] dbg_addr;
  logic          dbg_ack;
  logic [DW-1:0] dbg_rdata;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic          busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_addr,
    input  ram_rdata,
    output cpu_ack, cpu_rdata, dbg_ack, dbg_rdata,
    output ram_we, ram_addr, ram_wdata,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_addr,
    output ram_rdata,
    input  cpu_ack, cpu_rdata, dbg_ack, dbg_rdata,
    input  ram_we, ram_addr, ram_wdata,
    input  busy
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin pick (bit 0 = CPU, bit 1 = DBG) with the last-grant
// register; on a tie the port that did not win last time is chosen.
module mem_arbiter_rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic       grant_c_o,
  output logic       valid_c_o
);

  logic last_q, last_d;

  always_comb begin
    valid_c_o = |req_i;
    if (&req_i) begin
      grant_c_o = ~last_q;
    end else begin
      grant_c_o = req_i[1] ? OWN_DBG : OWN_CPU;
    end
    last_d = (update_i && valid_c_o) ? grant_c_o : last_q;
  end

  // DBG is "last" out of reset so the CPU wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= OWN_DBG;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU (read/write) and DBG (read-only) access to a shared
// single-port RAM; every access is IDLE -> ACC -> ACK with a one-cycle ack.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  mem_arbiter_if.slave   bus
);

  logic [1:0]    state_q, state_d;
  logic          owner_q, owner_d;
  ram_req_t      ram_q, ram_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          dbg_ack_q, dbg_ack_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
  logic          busy_q, busy_d;

  logic          gnt;
  logic          gnt_valid;

  mem_arbiter_rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .reset     (reset),
    .req_i     ({bus.dbg_req, bus.cpu_req}),
    .update_i  (state_q == ST_IDLE),
    .grant_c_o (gnt),
    .valid_c_o (gnt_valid)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ram_d       = ram_q;
    ram_d.we    = 1'b0;
    cpu_ack_d   = 1'b0;
    dbg_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          owner_d = gnt;
          state_d = ST_ACC;
          if (gnt == OWN_CPU) begin
            ram_d = '{we: bus.cpu_we, addr: bus.cpu_addr, wdata: bus.cpu_wdata};
          end else begin
            ram_d.addr = bus.dbg_addr;
          end
        end
      end
      // Read data captured here is the pre-write value on a CPU write.
      ST_ACC: begin
        state_d = ST_ACK;
        if (owner_q == OWN_CPU) begin
          cpu_rdata_d = bus.ram_rdata;
          cpu_ack_d   = 1'b1;
        end else begin
          dbg_rdata_d = bus.ram_rdata;
          dbg_ack_d   = 1'b1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_CPU;
      ram_q       <= '0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ram_q       <= ram_d;
      cpu_ack_q   <= cpu_ack_d;
      dbg_ack_q   <= dbg_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.ram_we    = ram_q.we;
  assign bus.ram_addr  = ram_q.addr;
  assign bus.ram_wdata = ram_q.wdata;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.dbg_ack   = dbg_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dbg_rdata = dbg_rdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 256x16 RAM
// (combinational read, clocked write).
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:255];
  logic          pre_we   = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  assign bus.ram_rdata = mem[bus.ram_addr];

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end

  int checks = 0;
  int errors = 0;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.dbg_req   = 1'b0;
    bus.dbg_addr  = '0;

    // Preload: addresses 0..3 hold 1..4, everything else zero
    pre_we = 1'b1;
    for (int i = 0; i < 256; i++) begin
      pre_addr = 8'(i);
      pre_data = (i < 4) ? 16'(i + 1) : 16'h0000;
      step();
    end
    pre_we = 1'b0;

    chk("rst_ram_we",    32'(bus.ram_we),    32'h0);
    chk("rst_ram_addr",  32'(bus.ram_addr),  32'h0);
    chk("rst_ram_wdata", 32'(bus.ram_wdata), 32'h0);
    chk("rst_cpu_ack",   32'(bus.cpu_ack),   32'h0);
    chk("rst_dbg_ack",   32'(bus.dbg_ack),   32'h0);
    chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'h0);
    chk("rst_dbg_rdata", 32'(bus.dbg_rdata), 32'h0);
    chk("rst_busy",      32'(bus.busy),      32'h0);

    reset = 1'b0;
    step();
    chk("idle_ram_we", 32'(bus.ram_we), 32'h0);
    chk("idle_busy",   32'(bus.busy),   32'h0);

    // CPU write 0x10 <= BEEF
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 8'h10;
    bus.cpu_wdata = 16'hBEEF;
    step();
    chk("wr_acc_we",    32'(bus.ram_we),    32'h1);
    chk("wr_acc_addr",  32'(bus.ram_addr),  32'h10);
    chk("wr_acc_wdata", 32'(bus.ram_wdata), 32'hBEEF);
    chk("wr_acc_busy",  32'(bus.busy),      32'h1);
    chk("wr_acc_ack",   32'(bus.cpu_ack),   32'h0);
    bus.cpu_addr  = 8'h55;
    bus.cpu_wdata = 16'h0000;
    bus.cpu_we    = 1'b0;
    step();
    chk("wr_ack_we",     32'(bus.ram_we),    32'h0);
    chk("wr_ack",        32'(bus.cpu_ack),   32'h1);
    chk("wr_prewrite",   32'(bus.cpu_rdata), 32'h0000);
    chk("wr_dbg_ack",    32'(bus.dbg_ack),   32'h0);
    chk("wr_committed",  32'(mem[8'h10]),    32'hBEEF);
    chk("wr_ack_busy",   32'(bus.busy),      32'h1);
    // Back-to-back read of 0x10 while cpu_req stays high
    bus.cpu_addr = 8'h10;
    bus.cpu_we   = 1'b0;
    step();
    chk("wr_ack_pulse", 32'(bus.cpu_ack), 32'h0);
    chk("wr_idle_busy", 32'(bus.busy),    32'h0);

    step();
    chk("rd_acc_we",   32'(bus.ram_we),   32'h0);
    chk("rd_acc_addr", 32'(bus.ram_addr), 32'h10);
    step();
    chk("rd_ack",     32'(bus.cpu_ack),   32'h1);
    chk("rd_rdata",   32'(bus.cpu_rdata), 32'hBEEF);
    chk("rd_dbg_ack", 32'(bus.dbg_ack),   32'h0);
    bus.cpu_req = 1'b0;
    step();
    chk("rd_hold", 32'(bus.cpu_rdata), 32'hBEEF);
    chk("rd_ack0", 32'(bus.cpu_ack),   32'h0);
    step();
    chk("rd_no_regrant", 32'(bus.busy), 32'h0);

    // Contention straight out of reset: CPU, DBG, CPU, DBG
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.cpu_req   = 1'b1;
    bus.dbg_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 8'h30;
    bus.cpu_wdata = 16'hA5A5;
    bus.dbg_addr  = 8'h02;
    for (int k = 0; k < 4; k++) begin
      logic is_dbg;
      is_dbg = (k % 2) == 1;
      step();
      chk("arb_addr", 32'(bus.ram_addr), is_dbg ? 32'h02 : 32'h30);
      chk("arb_we",   32'(bus.ram_we),   is_dbg ? 32'h0 : 32'h1);
      chk("arb_busy", 32'(bus.busy),     32'h1);
      step();
      chk("arb_cpu_ack", 32'(bus.cpu_ack), is_dbg ? 32'h0 : 32'h1);
      chk("arb_dbg_ack", 32'(bus.dbg_ack), is_dbg ? 32'h1 : 32'h0);
      if (is_dbg) chk("arb_dbg_rdata", 32'(bus.dbg_rdata), 32'h0003);
      else        chk("arb_cpu_rdata", 32'(bus.cpu_rdata), (k == 0) ? 32'h0000 : 32'hA5A5);
      if (k == 3) begin
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
      end
      step();
    end
    step();
    chk("arb_end_busy", 32'(bus.busy),   32'h0);
    chk("arb_mem",      32'(mem[8'h30]), 32'hA5A5);

    // DBG sweep 0..3 back-to-back
    bus.dbg_req  = 1'b1;
    bus.dbg_addr = 8'h00;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("sw_we",   32'(bus.ram_we),   32'h0);
      chk("sw_addr", 32'(bus.ram_addr), 32'(i));
      chk("sw_busy_acc", 32'(bus.busy), 32'h1);
      step();
      chk("sw_busy_ack", 32'(bus.busy),      32'h1);
      chk("sw_ack",      32'(bus.dbg_ack),   32'h1);
      chk("sw_cpu_ack",  32'(bus.cpu_ack),   32'h0);
      chk("sw_rdata",    32'(bus.dbg_rdata), 32'(i + 1));
      if (i == 3) bus.dbg_req = 1'b0;
      else        bus.dbg_addr = 8'(i + 1);
      step();
    end

    // CPU write to 0x20 aborted by reset during ACC
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 8'h20;
    bus.cpu_wdata = 16'hDEAD;
    step();
    chk("ab_acc_we",   32'(bus.ram_we),   32'h1);
    chk("ab_acc_addr", 32'(bus.ram_addr), 32'h20);
    #2;
    reset = 1'b1;
    #1;
    chk("ab_we",        32'(bus.ram_we),    32'h0);
    chk("ab_addr",      32'(bus.ram_addr),  32'h0);
    chk("ab_wdata",     32'(bus.ram_wdata), 32'h0);
    chk("ab_busy",      32'(bus.busy),      32'h0);
    chk("ab_cpu_ack",   32'(bus.cpu_ack),   32'h0);
    chk("ab_dbg_ack",   32'(bus.dbg_ack),   32'h0);
    chk("ab_cpu_rdata", 32'(bus.cpu_rdata), 32'h0);
    chk("ab_dbg_rdata", 32'(bus.dbg_rdata), 32'h0);
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    step();
    step();
    chk("ab_no_ack", 32'(bus.cpu_ack), 32'h0);
    chk("ab_mem",    32'(mem[8'h20]), 32'h0000);
    reset = 1'b0;
    step();

    // DBG read of 0x20 sees original contents
    bus.dbg_req  = 1'b1;
    bus.dbg_addr = 8'h20;
    step();
    chk("post_we", 32'(bus.ram_we), 32'h0);
    step();
    chk("post_ack",     32'(bus.dbg_ack),   32'h1);
    chk("post_rdata",   32'(bus.dbg_rdata), 32'h0000);
    chk("post_cpu_ack", 32'(bus.cpu_ack),   32'h0);
    bus.dbg_req = 1'b0;
    step();
    chk("post_ack_pulse", 32'(bus.dbg_ack), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
